afe_ads_frame_seq: RTL and testbench
====================================

AFE_ADS_FRAME_SEQ -- requirements
Module: afe_ads_frame_seq

Interface
REQ-001 SHALL have parameter NUM_AFE, default 2, AFE chips daisy-chained per ADS channel.
REQ-002 SHALL have parameter CH_PER_AFE, default 64, channels per AFE chip.
REQ-003 SHALL have parameter DATA_W, default 16, ADS sample width.
REQ-004 SHALL have parameter TMO_CYC, default 4096, maximum idle cycles between accepted samples within a frame.
REQ-005 SHALL have derived constants NPC = NUM_AFE*CH_PER_AFE and IDX_W = clog2(2*NPC).
REQ-006 sys_clk  in  1  single clock; all logic rising-edge.
REQ-007 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-008 ads_init_ok  in  1  ADS configured; sequencer leaves IDLE only while high.
REQ-009 sample_en  in  1  one-cycle frame trigger.
REQ-010 mode  in  2  00 A only, 01 B only, 10 A+B interleaved, 11 treated as 10; latched at frame start.
REQ-011 ads_adata / ads_avalid  in  DATA_W / 1  channel-A sample, valid one cycle.
REQ-012 ads_bdata / ads_bvalid  in  DATA_W / 1  channel-B sample, valid one cycle.
REQ-013 pix_data, pix_idx, pix_src, pix_sof, pix_eof, pix_valid  out  DATA_W, IDX_W, 1, 1, 1, 1  pixel stream; pix_src 0=A, 1=B.
REQ-014 pix_ready  in  1  downstream accept.
REQ-015 busy  out  1  high in CAPTURE; frame_done  out  1  one-cycle pulse at frame completion.
REQ-016 err_ovf, err_tmo  out  1 each, sticky; err_clr  in  1  clears both.

Function
REQ-017 States: IDLE, ARM, CAPTURE. IDLE->ARM when ads_init_ok=1; ARM->CAPTURE on sample_en=1, latching mode and zeroing counters.
REQ-018 Each enabled channel SHALL count samples 0..NPC-1; disabled-channel valids SHALL be discarded silently.
REQ-019 Accepted sample SHALL load a per-channel holding register; pix_valid SHALL be asserted the next cycle (latency 1).
REQ-020 pix_idx SHALL be the sample count for A, and NPC + count for B.
REQ-021 In interleaved mode, output SHALL alternate A,B,A,B starting with A; a pending B SHALL wait for its preceding A.
REQ-022 pix_data, pix_idx, pix_src, pix_sof and pix_eof SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-023 A beat transfers when pix_valid and pix_ready are both 1.
REQ-024 Sample arriving while its holding register is full and not transferring this cycle SHALL be dropped, set err_ovf and still advance the count.
REQ-025 pix_sof SHALL mark the first transferred beat of a frame.
REQ-026 pix_eof SHALL mark the beat after which all enabled counts equal NPC and both holds are empty.
REQ-027 frame_done SHALL pulse in the cycle after the eof transfer; state then returns to ARM.
REQ-028 The timeout counter SHALL reset on each accepted sample; reaching TMO_CYC in CAPTURE SHALL set err_tmo, clear holds and return to ARM without frame_done.
REQ-029 ads_init_ok falling in any state SHALL force IDLE next cycle, clear holds and deassert pix_valid.
REQ-030 sample_en in CAPTURE SHALL be ignored.
REQ-031 err_clr coincident with a new error event SHALL leave the error flag set.

Reset
REQ-032 sys_rst_n=0 at a clock edge SHALL give: state IDLE; all counters and holds 0; pix_valid, pix_sof, pix_eof, busy, frame_done, err_ovf and err_tmo 0; pix_data, pix_idx and pix_src 0.
REQ-033 Reset mid-frame SHALL discard the frame; no eof and no frame_done SHALL be emitted.

Structure
REQ-034 Mode encodings, state encoding and the clog2 function SHALL reside in shared package afe_ads_pkg.
REQ-035 One sub-module, afe_ads_hold, SHALL implement the per-channel holding register with overflow detection, instantiated twice.

Verification (NUM_AFE=2, CH_PER_AFE=4, TMO_CYC=32)
REQ-036 Mode 00, 8 A samples spaced 3 cycles, pix_ready=1 -> idx 0..7, sof on idx 0, eof on idx 7, frame_done once.
REQ-037 Mode 10, A and B valid in the same cycles, 8 each -> order A0,B8,A1,B9...A7,B15; eof on idx 15.
REQ-038 Mode 00, pix_ready=0 for 10 cycles with 2 A samples arriving -> second sample dropped, err_ovf=1, next output idx 2.
REQ-039 Mode 01, 3 B samples then silence -> err_tmo=1 after 32 cycles, no frame_done, state ARM.
REQ-040 ads_init_ok low after 4 samples -> pix_valid=0 next cycle, state IDLE; err_clr with ovf event -> err_ovf remains 1.

Source files
------------

// File: rtl/afe_ads_pkg.sv
// Shared encodings and helpers for the ADS frame sequencer.
package afe_ads_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_A      = 2'b00,
      MODE_B      = 2'b01,
      MODE_AB     = 2'b10,
      MODE_AB_ALT = 2'b11
   } mode_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/afe_ads_frame_seq_if.sv
// Pixel stream bundle between the frame sequencer and its downstream consumer.
interface afe_ads_frame_seq_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
);
   logic [DATA_W-1:0] pix_data;
   logic [IDX_W-1:0]  pix_idx;
   logic              pix_src;
   logic              pix_sof;
   logic              pix_eof;
   logic              pix_valid;
   logic              pix_ready;

   modport master (
      output pix_data, pix_idx, pix_src, pix_sof, pix_eof, pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data, pix_idx, pix_src, pix_sof, pix_eof, pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/afe_ads_hold.sv
// Single-entry sample holding register; flags a sample that finds it occupied.
module afe_ads_hold #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic              take_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic              full_o,
   output logic [DATA_W-1:0] data_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              ovf_o
);
   logic              full_q, full_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  idx_q,  idx_d;

   // Load when empty or draining this cycle; otherwise the new sample is lost.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      idx_d  = idx_q;
      if (clr_i) begin
         full_d = 1'b0;
         data_d = '0;
         idx_d  = '0;
      end else if (load_i && (!full_q || take_i)) begin
         full_d = 1'b1;
         data_d = data_i;
         idx_d  = idx_i;
      end else if (take_i) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Holding register state.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         full_q <= 1'b0;
         data_q <= '0;
         idx_q  <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
         idx_q  <= idx_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;
   assign idx_o  = idx_q;
   assign ovf_o  = load_i & full_q & ~take_i & ~clr_i;
endmodule

// File: rtl/afe_ads_frame_seq.sv
// Frame sequencer: collects ADS channel A/B samples into an indexed pixel stream.
module afe_ads_frame_seq
   import afe_ads_pkg::*;
#(
   parameter int NUM_AFE    = 2,
   parameter int CH_PER_AFE = 64,
   parameter int DATA_W     = 16,
   parameter int TMO_CYC    = 4096
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              ads_init_ok,
   input  logic              sample_en,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] ads_adata,
   input  logic              ads_avalid,
   input  logic [DATA_W-1:0] ads_bdata,
   input  logic              ads_bvalid,
   afe_ads_frame_seq_if.master pix,
   output logic              busy,
   output logic              frame_done,
   output logic              err_ovf,
   output logic              err_tmo,
   input  logic              err_clr,
   output logic [1:0]        dbg_state
);
   localparam int NPC   = NUM_AFE * CH_PER_AFE;
   localparam int IDX_W = clog2(2 * NPC);
   localparam int TMO_W = clog2(TMO_CYC + 1);
   localparam logic [IDX_W-1:0] NPC_C    = IDX_W'(NPC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [IDX_W-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              turn_q, turn_d, first_q, first_d, done_q, done_d;
   logic              err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;

   logic              cap_s, en_a_s, en_b_s, acc_a_s, acc_b_s, all_done_s;
   logic              sel_b_s, xfer_s, eof_xfer_s, tmo_fire_s, flush_s;
   logic              full_a_s, full_b_s, ovf_a_s, ovf_b_s;
   logic [DATA_W-1:0] data_a_s, data_b_s;
   logic [IDX_W-1:0]  idx_a_s, idx_b_s;

   assign cap_s      = (state_q == ST_CAPTURE);
   assign en_a_s     = (mode_q != MODE_B);
   assign en_b_s     = (mode_q != MODE_A);
   assign acc_a_s    = cap_s & ads_init_ok & en_a_s & ads_avalid & (cnt_a_q < NPC_C);
   assign acc_b_s    = cap_s & ads_init_ok & en_b_s & ads_bvalid & (cnt_b_q < NPC_C);
   assign all_done_s = (!en_a_s || (cnt_a_q == NPC_C)) && (!en_b_s || (cnt_b_q == NPC_C));
   assign tmo_fire_s = cap_s & ads_init_ok & ~acc_a_s & ~acc_b_s & ~all_done_s & (tmo_q == TMO_LAST);
   assign flush_s    = ~ads_init_ok | tmo_fire_s;

   // Interleaved output alternates on a turn bit that only flips on a transfer,
   // so the presented beat never changes while stalled.
   assign sel_b_s    = (mode_q == MODE_B) ? 1'b1 : ((mode_q == MODE_A) ? 1'b0 : turn_q);
   assign pix.pix_valid = cap_s & (sel_b_s ? full_b_s : full_a_s);
   assign pix.pix_data  = sel_b_s ? data_b_s : data_a_s;
   assign pix.pix_idx   = sel_b_s ? idx_b_s : idx_a_s;
   assign pix.pix_src   = sel_b_s;
   assign pix.pix_sof   = pix.pix_valid & first_q;
   assign pix.pix_eof   = pix.pix_valid & all_done_s & (sel_b_s ? ~full_a_s : ~full_b_s);
   assign xfer_s        = pix.pix_valid & pix.pix_ready;
   assign eof_xfer_s    = xfer_s & pix.pix_eof;

   afe_ads_hold #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_hold_a (
      .clk_i(sys_clk), .rst_n_i(sys_rst_n), .clr_i(flush_s), .load_i(acc_a_s),
      .take_i(xfer_s & ~sel_b_s), .data_i(ads_adata), .idx_i(cnt_a_q),
      .full_o(full_a_s), .data_o(data_a_s), .idx_o(idx_a_s), .ovf_o(ovf_a_s)
   );

   afe_ads_hold #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_hold_b (
      .clk_i(sys_clk), .rst_n_i(sys_rst_n), .clr_i(flush_s), .load_i(acc_b_s),
      .take_i(xfer_s & sel_b_s), .data_i(ads_bdata), .idx_i(NPC_C + cnt_b_q),
      .full_o(full_b_s), .data_o(data_b_s), .idx_o(idx_b_s), .ovf_o(ovf_b_s)
   );

   // Sequencer next state, per-frame counters and sticky error flags.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_a_d   = cnt_a_q;
      cnt_b_d   = cnt_b_q;
      turn_d    = turn_q;
      first_d   = first_q;
      tmo_d     = '0;
      done_d    = 1'b0;
      err_ovf_d = (err_ovf_q & ~err_clr) | ovf_a_s | ovf_b_s;
      err_tmo_d = (err_tmo_q & ~err_clr) | tmo_fire_s;
      if (!ads_init_ok) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_ARM;
            ST_ARM: begin
               if (sample_en) begin
                  state_d = ST_CAPTURE;
                  mode_d  = mode_e'(mode);
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  turn_d  = 1'b0;
                  first_d = 1'b1;
               end else begin
                  state_d = ST_ARM;
               end
            end
            ST_CAPTURE: begin
               cnt_a_d = acc_a_s ? cnt_a_q + 1'b1 : cnt_a_q;
               cnt_b_d = acc_b_s ? cnt_b_q + 1'b1 : cnt_b_q;
               tmo_d   = (acc_a_s || acc_b_s || all_done_s) ? '0 : tmo_q + 1'b1;
               if (xfer_s) begin
                  first_d = 1'b0;
                  turn_d  = mode_q[1] ? ~turn_q : turn_q;
               end else begin
                  first_d = first_q;
               end
               if (eof_xfer_s) begin
                  state_d = ST_ARM;
                  done_d  = 1'b1;
               end else if (tmo_fire_s) begin
                  state_d = ST_ARM;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Sequencer registers.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_A;
         cnt_a_q   <= '0;
         cnt_b_q   <= '0;
         tmo_q     <= '0;
         turn_q    <= 1'b0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
         err_ovf_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         cnt_a_q   <= cnt_a_d;
         cnt_b_q   <= cnt_b_d;
         tmo_q     <= tmo_d;
         turn_q    <= turn_d;
         first_q   <= first_d;
         done_q    <= done_d;
         err_ovf_q <= err_ovf_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign busy       = cap_s;
   assign frame_done = done_q;
   assign err_ovf    = err_ovf_q;
   assign err_tmo    = err_tmo_q;
   assign dbg_state  = state_q;
endmodule

// File: tb/tb_afe_ads_frame_seq.sv
// Scoreboard bench for afe_ads_frame_seq with a small 2x4-channel configuration.
module tb_afe_ads_frame_seq;
   import afe_ads_pkg::*;

   localparam int NUM_AFE = 2, CH_PER_AFE = 4, DATA_W = 16, TMO_CYC = 32;
   localparam int IDX_W = 4;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  idx;
      logic        src;
      logic        sof;
      logic        eof;
   } beat_t;

   logic        sys_clk = 1'b0, sys_rst_n = 1'b0, ads_init_ok = 1'b0, sample_en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [15:0] ads_adata = 16'h0, ads_bdata = 16'h0;
   logic        ads_avalid = 1'b0, ads_bvalid = 1'b0, err_clr = 1'b0;
   logic        busy, frame_done, err_ovf, err_tmo;
   logic [1:0]  dbg_state;

   beat_t exp_q[$];
   int    checks = 0, errors = 0, fd_cnt = 0;
   beat_t prev_b;
   logic  prev_stall = 1'b0;

   afe_ads_frame_seq_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) pif ();

   afe_ads_frame_seq #(
      .NUM_AFE(NUM_AFE), .CH_PER_AFE(CH_PER_AFE), .DATA_W(DATA_W), .TMO_CYC(TMO_CYC)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ads_init_ok(ads_init_ok),
      .sample_en(sample_en), .mode(mode), .ads_adata(ads_adata), .ads_avalid(ads_avalid),
      .ads_bdata(ads_bdata), .ads_bvalid(ads_bvalid), .pix(pif.master), .busy(busy),
      .frame_done(frame_done), .err_ovf(err_ovf), .err_tmo(err_tmo), .err_clr(err_clr),
      .dbg_state(dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [3:0] idx, input logic src,
                       input logic sof, input logic eof);
      exp_q.push_back({d, idx, src, sof, eof});
   endtask

   task automatic send(input logic av, input logic [15:0] ad, input logic bv, input logic [15:0] bd);
      ads_avalid = av; ads_adata = ad; ads_bvalid = bv; ads_bdata = bd;
      cyc(1);
      ads_avalid = 1'b0; ads_bvalid = 1'b0;
   endtask

   task automatic start(input logic [1:0] m);
      mode = m; sample_en = 1'b1;
      cyc(1);
      sample_en = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         cyc(1);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: frame_done counter, stall stability and in-order beat comparison.
   always @(negedge sys_clk) begin
      beat_t cur, e;
      cur = {pif.pix_data, pif.pix_idx, pif.pix_src, pif.pix_sof, pif.pix_eof};
      if (frame_done) fd_cnt++;
      if (sys_rst_n && prev_stall && pif.pix_valid) chk("hold_stable", cur, prev_b);
      if (pif.pix_valid && pif.pix_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
         end else begin
            e = exp_q.pop_front();
            chk("beat", cur, e);
         end
      end
      prev_stall = pif.pix_valid & ~pif.pix_ready;
      prev_b = cur;
   end

   initial begin
      int n;
      pif.pix_ready = 1'b1;
      cyc(3);
      chk("rst_valid", pif.pix_valid, 0);
      chk("rst_sof_eof", {pif.pix_sof, pif.pix_eof}, 0);
      chk("rst_data_idx", {pif.pix_data, pif.pix_idx, pif.pix_src}, 0);
      chk("rst_flags", {busy, frame_done, err_ovf, err_tmo}, 0);
      chk("rst_state", dbg_state, ST_IDLE);
      sys_rst_n = 1'b1; ads_init_ok = 1'b1;
      cyc(1);
      chk("arm_state", dbg_state, ST_ARM);

      // A-only frame, samples every 3 cycles
      fd_cnt = 0;
      start(MODE_A);
      chk("busy_cap", busy, 1);
      for (int i = 0; i < 8; i++) begin
         push(16'hA000 + 16'(i), 4'(i), 1'b0, i == 0, i == 7);
         send(1'b1, 16'hA000 + 16'(i), 1'b0, 16'h0);
         cyc(2);
      end
      drain("t1_drain");
      cyc(2);
      chk("t1_frame_done", fd_cnt, 1);
      chk("t1_state", dbg_state, ST_ARM);

      // Interleaved frame, A and B arriving together
      fd_cnt = 0;
      start(MODE_AB);
      for (int i = 0; i < 8; i++) begin
         push(16'hA100 + 16'(i), 4'(i), 1'b0, i == 0, 1'b0);
         push(16'hB100 + 16'(i), 4'(8 + i), 1'b1, 1'b0, i == 7);
         send(1'b1, 16'hA100 + 16'(i), 1'b1, 16'hB100 + 16'(i));
         cyc(2);
      end
      drain("t2_drain");
      cyc(2);
      chk("t2_frame_done", fd_cnt, 1);

      // Stalled output: second sample overflows but still consumes an index
      fd_cnt = 0;
      start(MODE_A);
      pif.pix_ready = 1'b0;
      push(16'hA200, 4'd0, 1'b0, 1'b1, 1'b0);
      send(1'b1, 16'hA200, 1'b0, 16'h0);
      cyc(2);
      send(1'b1, 16'hA201, 1'b0, 16'h0);
      cyc(6);
      chk("t3_err_ovf", err_ovf, 1);
      pif.pix_ready = 1'b1;
      cyc(1);
      for (int i = 2; i < 8; i++) begin
         push(16'hA200 + 16'(i), 4'(i), 1'b0, 1'b0, i == 7);
         send(1'b1, 16'hA200 + 16'(i), 1'b0, 16'h0);
         cyc(2);
      end
      drain("t3_drain");
      cyc(2);
      chk("t3_frame_done", fd_cnt, 1);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("t3_ovf_cleared", err_ovf, 0);

      // B-only frame that stops early and times out
      fd_cnt = 0;
      start(MODE_B);
      for (int i = 0; i < 3; i++) begin
         push(16'hB300 + 16'(i), 4'(8 + i), 1'b1, i == 0, 1'b0);
         if (i != 0) cyc(2);
         send(1'b0, 16'h0, 1'b1, 16'hB300 + 16'(i));
      end
      n = 0;
      while (!err_tmo && n < 60) begin
         cyc(1);
         n++;
      end
      chk("t4_tmo_cycles", n, 32);
      chk("t4_err_tmo", err_tmo, 1);
      chk("t4_state", dbg_state, ST_ARM);
      chk("t4_queue", exp_q.size(), 0);
      cyc(2);
      chk("t4_no_done", fd_cnt, 0);
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("t4_tmo_cleared", err_tmo, 0);

      // init_ok loss with a beat pending
      fd_cnt = 0;
      start(MODE_A);
      for (int i = 0; i < 3; i++) begin
         push(16'hA400 + 16'(i), 4'(i), 1'b0, i == 0, 1'b0);
         send(1'b1, 16'hA400 + 16'(i), 1'b0, 16'h0);
         cyc(2);
      end
      pif.pix_ready = 1'b0;
      send(1'b1, 16'hA403, 1'b0, 16'h0);
      chk("t5_valid_before", pif.pix_valid, 1);
      ads_init_ok = 1'b0;
      cyc(1);
      chk("t5_valid_after", pif.pix_valid, 0);
      chk("t5_state_idle", dbg_state, ST_IDLE);
      pif.pix_ready = 1'b1;
      cyc(2);
      chk("t5_no_done", fd_cnt, 0);
      chk("t5_queue", exp_q.size(), 0);

      // err_clr coincident with an overflow event
      ads_init_ok = 1'b1;
      cyc(1);
      start(MODE_A);
      pif.pix_ready = 1'b0;
      push(16'hA500, 4'd0, 1'b0, 1'b1, 1'b0);
      send(1'b1, 16'hA500, 1'b0, 16'h0);
      err_clr = 1'b1;
      send(1'b1, 16'hA501, 1'b0, 16'h0);
      err_clr = 1'b0;
      chk("t6_ovf_kept", err_ovf, 1);
      pif.pix_ready = 1'b1;
      cyc(2);
      chk("t6_queue", exp_q.size(), 0);

      // Reset in the middle of a frame discards it
      fd_cnt = 0;
      pif.pix_ready = 1'b0;
      send(1'b1, 16'hA502, 1'b0, 16'h0);
      sys_rst_n = 1'b0;
      cyc(2);
      sys_rst_n = 1'b1;
      pif.pix_ready = 1'b1;
      cyc(3);
      chk("t7_valid", pif.pix_valid, 0);
      chk("t7_flags", {busy, err_ovf, err_tmo}, 0);
      chk("t7_no_done", fd_cnt, 0);
      chk("t7_state", dbg_state, ST_ARM);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
